// File: rtl/wtm_seq10_if.sv
// rtl/wtm_seq10_if.sv - operand/result handshake bundle for the 10x10 multiply sequencer
interface wtm_seq10_if;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  a;
    logic [9:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] product;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/wtm_seq10.sv
// rtl/wtm_seq10.sv - 10x10 multiply built from four passes through one 5x5 Wallace-tree multiplier
module wtm (
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic [9:0] result,
    output logic       cout
);
    logic [10:0] pp [5];
    logic [10:0] s1, c1, s2, c2, s3, c3, sum;

    // partial products, one row per multiplier bit
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            pp[i] = b[i] ? ({6'b0, a} << i) : 11'd0;
        end
    end

    // three carry-save levels reduce five rows to two, then one carry-propagate add
    assign s1  = pp[0] ^ pp[1] ^ pp[2];
    assign c1  = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
    assign s2  = s1 ^ c1 ^ pp[3];
    assign c2  = ((s1 & c1) | (s1 & pp[3]) | (c1 & pp[3])) << 1;
    assign s3  = s2 ^ c2 ^ pp[4];
    assign c3  = ((s2 & c2) | (s2 & pp[4]) | (c2 & pp[4])) << 1;
    assign sum = s3 + c3;

    assign result = sum[9:0];
    assign cout   = sum[10];
endmodule

module wtm_seq10 #(
    parameter bit ZERO_SKIP = 1'b1
) (
    input  logic          clock,
    input  logic          resetn,
    wtm_seq10_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  pass_q, pass_d;
    logic [9:0]  ra_q, ra_d;
    logic [9:0]  rb_q, rb_d;
    logic [19:0] acc_q, acc_d;
    logic [19:0] product_q, product_d;
    logic        out_valid_q, out_valid_d;

    logic        accept;
    logic        zero_op;
    logic [4:0]  w_a, w_b;
    logic [9:0]  w_result;
    logic        w_cout_unused;
    logic [19:0] partial;

    assign bus.in_ready  = (state_q == IDLE) || (state_q == DONE && bus.out_ready);
    assign bus.busy      = (state_q == MUL);
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign zero_op = ZERO_SKIP && (bus.a == 10'd0 || bus.b == 10'd0);

    // select the operand halves for the current pass
    always_comb begin
        w_a = ra_q[4:0];
        w_b = rb_q[4:0];
        case (pass_q)
            2'd1:    w_a = ra_q[9:5];
            2'd2:    w_b = rb_q[9:5];
            2'd3:    begin w_a = ra_q[9:5]; w_b = rb_q[9:5]; end
            default: ;
        endcase
    end

    // the 5x5 product never exceeds 10 bits, so its carry-out carries no information
    wtm u_wtm (
        .a      (w_a),
        .b      (w_b),
        .result (w_result),
        .cout   (w_cout_unused)
    );

    // align the pass product to its weight in the 20-bit result
    always_comb begin
        partial = {10'b0, w_result};
        case (pass_q)
            2'd1, 2'd2: partial = {5'b0, w_result, 5'b0};
            2'd3:       partial = {w_result, 10'b0};
            default:    ;
        endcase
    end

    // next-state: run passes, hold the result until taken, and latch new operands on accept
    always_comb begin
        state_d     = state_q;
        pass_d      = pass_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        acc_d       = acc_q;
        product_d   = product_q;
        out_valid_d = out_valid_q;

        case (state_q)
            MUL: begin
                acc_d  = acc_q + partial;
                pass_d = pass_q + 2'd1;
                if (pass_q == 2'd3) begin
                    product_d   = acc_q + partial;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: ;
        endcase

        // an accept in DONE coincides with the handoff above and overrides its next state
        if (accept) begin
            ra_d   = bus.a;
            rb_d   = bus.b;
            acc_d  = 20'd0;
            pass_d = 2'd0;
            if (zero_op) begin
                product_d   = 20'd0;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end else begin
                out_valid_d = 1'b0;
                state_d     = MUL;
            end
        end
    end

    // state and datapath registers; reset discards any in-flight multiply
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            pass_q      <= 2'd0;
            ra_q        <= 10'd0;
            rb_q        <= 10'd0;
            acc_q       <= 20'd0;
            product_q   <= 20'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pass_q      <= pass_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_wtm_seq10.sv
// tb/tb_wtm_seq10.sv - directed self-checking bench for wtm_seq10
module tb_wtm_seq10;
    logic clock;
    logic resetn;
    int   total;
    int   passed;

    wtm_seq10_if m ();
    wtm_seq10_if z ();

    wtm_seq10 #(.ZERO_SKIP(1'b1)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (m)
    );

    wtm_seq10 #(.ZERO_SKIP(1'b0)) dut_nz (
        .clock  (clock),
        .resetn (resetn),
        .bus    (z)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // accept one pair on the main instance, measure edges to result, check it, then take it
    task automatic run_op(input string tag, input logic [9:0] av, input logic [9:0] bv,
                          input logic [19:0] exp_p, input int exp_lat);
        int n;
        m.a        = av;
        m.b        = bv;
        m.in_valid = 1'b1;
        m.out_ready = 1'b0;
        tick();
        m.in_valid = 1'b0;
        m.a        = 10'h3ff;
        m.b        = 10'h3ff;
        n = 0;
        if (exp_lat == 0) chk({tag, "_busy_low"}, 32'(m.busy), 32'd0);
        while (!m.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        chk({tag, "_product"}, 32'(m.product), 32'(exp_p));
        m.out_ready = 1'b1;
        tick();
        m.out_ready = 1'b0;
        chk({tag, "_taken"}, 32'(m.out_valid), 32'd0);
    endtask

    initial begin
        int n;
        logic [9:0]  ta [3];
        logic [9:0]  tb [3];
        logic [19:0] tp [3];

        total  = 0;
        passed = 0;
        resetn = 1'b0;
        m.in_valid = 1'b0; m.a = '0; m.b = '0; m.out_ready = 1'b0;
        z.in_valid = 1'b0; z.a = '0; z.b = '0; z.out_ready = 1'b1;
        tick();
        tick();
        chk("rst_in_ready", 32'(m.in_ready), 32'd1);
        chk("rst_out_valid", 32'(m.out_valid), 32'd0);
        chk("rst_product", 32'(m.product), 32'd0);
        chk("rst_busy", 32'(m.busy), 32'd0);
        resetn = 1'b1;
        tick();

        // max operands, busy for exactly four cycles
        m.a = 10'd1023; m.b = 10'd1023; m.in_valid = 1'b1;
        tick();
        m.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("max_busy", 32'(m.busy), 32'd1);
            chk("max_in_ready_low", 32'(m.in_ready), 32'd0);
            tick();
        end
        chk("max_out_valid", 32'(m.out_valid), 32'd1);
        chk("max_product", 32'(m.product), 32'd1046529);
        chk("max_busy_done", 32'(m.busy), 32'd0);
        m.out_ready = 1'b1;
        tick();
        m.out_ready = 1'b0;
        chk("max_taken", 32'(m.out_valid), 32'd0);

        run_op("p31", 10'd31, 10'd31, 20'd961, 4);
        run_op("p32", 10'd32, 10'd32, 20'd1024, 4);
        run_op("mix", 10'd37, 10'd900, 20'd33300, 4);
        run_op("zs_a0", 10'd0, 10'd777, 20'd0, 0);
        run_op("zs_b0", 10'd555, 10'd0, 20'd0, 0);

        // same zero operand without skipping takes the full four passes
        z.out_ready = 1'b0;
        z.a = 10'd0; z.b = 10'd777; z.in_valid = 1'b1;
        tick();
        z.in_valid = 1'b0;
        chk("nz_busy", 32'(z.busy), 32'd1);
        n = 0;
        while (!z.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("nz_latency", 32'(n), 32'd4);
        chk("nz_product", 32'(z.product), 32'd0);
        z.out_ready = 1'b1;
        tick();

        // backpressure: result and in_ready hold while out_ready is low
        m.a = 10'd600; m.b = 10'd700; m.in_valid = 1'b1; m.out_ready = 1'b0;
        tick();
        m.in_valid = 1'b0;
        n = 0;
        while (!m.out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("bp_latency", 32'(n), 32'd4);
        for (int i = 0; i < 6; i++) begin
            chk("bp_product_hold", 32'(m.product), 32'd420000);
            chk("bp_valid_hold", 32'(m.out_valid), 32'd1);
            chk("bp_in_ready_low", 32'(m.in_ready), 32'd0);
            tick();
        end
        m.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_comb", 32'(m.in_ready), 32'd1);
        tick();
        m.out_ready = 1'b0;
        #1;
        chk("bp_taken", 32'(m.out_valid), 32'd0);
        chk("bp_idle", 32'(m.in_ready), 32'd1);

        // back-to-back: each new accept lands on the previous handoff
        ta[0] = 10'd3;    tb[0] = 10'd5;   tp[0] = 20'd15;
        ta[1] = 10'd1000; tb[1] = 10'd2;   tp[1] = 20'd2000;
        ta[2] = 10'd513;  tb[2] = 10'd514; tp[2] = 20'd263682;
        tick();
        m.out_ready = 1'b1;
        m.a = ta[0]; m.b = tb[0]; m.in_valid = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                m.a = ta[k];
                m.b = tb[k];
            end
            n = 0;
            do begin
                tick();
                n++;
            end while (!m.out_valid && n < 20);
            chk($sformatf("b2b%0d_gap", k), 32'(n), (k == 0) ? 32'd4 : 32'd5);
            chk($sformatf("b2b%0d_product", k), 32'(m.product), 32'(tp[k]));
        end
        m.in_valid = 1'b0;
        tick();
        chk("b2b_end_taken", 32'(m.out_valid), 32'd0);
        chk("b2b_end_busy", 32'(m.busy), 32'd0);
        m.out_ready = 1'b0;

        // reset while pass 2 is pending discards the operation
        m.a = 10'd999; m.b = 10'd999; m.in_valid = 1'b1;
        tick();
        m.in_valid = 1'b0;
        tick();
        tick();
        chk("mid_busy_before", 32'(m.busy), 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(m.busy), 32'd0);
        chk("mid_rst_in_ready", 32'(m.in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(m.out_valid), 32'd0);
        chk("mid_rst_product", 32'(m.product), 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        chk("mid_no_result", 32'(m.out_valid), 32'd0);
        run_op("after_rst", 10'd7, 10'd9, 20'd63, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
